alu_issue_ctrl: RTL and testbench

//  - Drives the 16-bit ALU: accepts one instruction per valid/ready handshake.
//  - Reads two operands from an internal register file and presents X/Y/opcod/Cin to the ALU.
//  - Captures out/Cout/lt/eq/gt and writes the result back to the register file.
//  - Sits between the instruction source and the ALU; the ALU itself is purely combinational.

---
 rtl/alu_issue_ctrl_if.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 87 ++++++++
 tb/tb_alu_issue_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, ALU operand/result and writeback report bundle.
// master = the controller, slave = instruction source plus combinational ALU.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [2:0]        alu_op;
    logic              alu_cin;
    logic [DATA_W-1:0] alu_out;
    logic              alu_cout;
    logic              alu_lt;
    logic              alu_eq;
    logic              alu_gt;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [3:0]        res_flags;
    logic              illegal;

    modport master (
        input  instr_valid, instr, alu_out, alu_cout, alu_lt, alu_eq, alu_gt,
        output instr_ready, alu_x, alu_y, alu_op, alu_cin, res_valid, res_data, res_flags, illegal
    );

    modport slave (
        output instr_valid, instr, alu_out, alu_cout, alu_lt, alu_eq, alu_gt,
        input  instr_ready, alu_x, alu_y, alu_op, alu_cin, res_valid, res_data, res_flags, illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one register-file instruction at a time to a combinational ALU and writes back.
// Optional ALU_ISSUE_R0ZERO_EN: register 0 reads as zero and ignores all writes.
module alu_issue_ctrl #(
    parameter int DATA_W   = 16,
    parameter int NREG     = 8,
    parameter bit CARRY_IN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.master  bus,
    input  logic              rf_we,
    input  logic [2:0]        rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    input  logic [2:0]        rf_raddr,
    output logic [DATA_W-1:0] rf_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] x_q, y_q, res_q;
    logic [2:0]        op_q, rd_q;
    logic [3:0]        flags_q;
    logic              uc_q, carry_q, illegal_q;
    logic              accept, legal, in_issue, wb_we, pl_we;
    logic              unused_bits;

    assign unused_bits = ^bus.instr[3:1];

    always_comb begin
        accept          = state == IDLE && bus.instr_valid;
        legal           = ~bus.instr[15];
        in_issue        = state == ISSUE;
        state_nx        = state == IDLE ? (accept && legal ? ISSUE : IDLE) : in_issue ? WB : IDLE;
        bus.instr_ready = state == IDLE && rst_n;
        bus.alu_x       = in_issue ? x_q : '0;
        bus.alu_y       = in_issue ? y_q : '0;
        bus.alu_op      = in_issue ? op_q : 3'd0;
        bus.alu_cin     = in_issue & CARRY_IN & uc_q & carry_q;
        bus.res_valid   = state == WB;
        bus.res_data    = res_q;
        bus.res_flags   = flags_q;
        bus.illegal     = illegal_q;
`ifdef ALU_ISSUE_R0ZERO_EN
        wb_we           = state == WB && rd_q != 3'd0;
        pl_we           = state == IDLE && rf_we && rf_waddr != 3'd0;
`else
        wb_we           = state == WB;
        pl_we           = state == IDLE && rf_we;
`endif
        rf_rdata        = rf[rf_raddr];
    end

    // operands are read at acceptance, so a same-cycle preload is seen only by later instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            res_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            flags_q   <= '0;
            uc_q      <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            state     <= state_nx;
            illegal_q <= accept & ~legal;
            if (accept) begin
                op_q <= bus.instr[15:13];
                rd_q <= bus.instr[12:10];
                x_q  <= rf[bus.instr[9:7]];
                y_q  <= rf[bus.instr[6:4]];
                uc_q <= bus.instr[0];
            end
            if (in_issue) begin
                res_q   <= bus.alu_out;
                flags_q <= {bus.alu_cout, bus.alu_lt, bus.alu_eq, bus.alu_gt};
            end
            if (wb_we) rf[rd_q] <= res_q;
            if (state == WB) carry_q <= flags_q[3];
            if (pl_we) rf[rf_waddr] <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random instructions against a register-file/carry reference model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rf_we = 1'b0;
    logic [2:0]  rf_waddr = '0;
    logic [15:0] rf_wdata = '0;
    logic [2:0]  rf_raddr = '0;
    logic [15:0] rf_rdata;
    logic [16:0] alu_t;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_rf [8];
    logic        ref_carry;

    alu_issue_ctrl_if #(.DATA_W(16)) bus ();

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // combinational ALU: sub reports borrow as cout
    always_comb begin
        alu_t = '0;
        case (bus.alu_op)
            3'd0: alu_t = {1'b0, bus.alu_x} + {1'b0, bus.alu_y} + 17'(bus.alu_cin);
            3'd1: alu_t = {1'b0, bus.alu_x} - {1'b0, bus.alu_y} - 17'(bus.alu_cin);
            3'd2: alu_t = {1'b0, bus.alu_x & bus.alu_y};
            3'd3: alu_t = {1'b0, bus.alu_x | bus.alu_y};
            default: alu_t = '0;
        endcase
        bus.alu_out  = alu_t[15:0];
        bus.alu_cout = alu_t[16];
        bus.alu_lt   = bus.alu_x < bus.alu_y;
        bus.alu_eq   = bus.alu_x == bus.alu_y;
        bus.alu_gt   = bus.alu_x > bus.alu_y;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_write(input logic [2:0] a, input logic [15:0] d);
`ifdef ALU_ISSUE_R0ZERO_EN
        if (a != 3'd0) ref_rf[a] = d;
`else
        ref_rf[a] = d;
`endif
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        ref_carry = 1'b0;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        @(posedge clk);
        #1 rf_we = 1'b0;
        ref_write(a, d);
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a);
        rf_raddr = a;
        #1 chk(tag, rf_rdata, ref_rf[a]);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic uc, input logic pl_en,
                         input logic [2:0] pl_a, input logic [15:0] pl_d);
        logic [15:0] a, b, res;
        logic        cin, co;
        int          s;
        a = ref_rf[rs1]; b = ref_rf[rs2]; cin = uc & ref_carry;
        s = 0; res = '0; co = 1'b0;
        case (op)
            3'd0: begin s = int'(a) + int'(b) + int'(cin); res = 16'(s); co = s > 65535; end
            3'd1: begin s = int'(a) - int'(b) - int'(cin); res = 16'(s); co = s < 0; end
            3'd2: res = a & b;
            default: res = a | b;
        endcase
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = {op, rd, rs1, rs2, 3'b000, uc};
        rf_we = pl_en; rf_waddr = pl_a; rf_wdata = pl_d;
        chk("ready_idle", bus.instr_ready, 1);
        @(posedge clk);
        #1 bus.instr_valid = 1'b0; rf_we = 1'b0;
        if (pl_en) ref_write(pl_a, pl_d);
        @(negedge clk);
        chk("alu_x", bus.alu_x, a);
        chk("alu_y", bus.alu_y, b);
        chk("alu_op", bus.alu_op, op);
        chk("alu_cin", bus.alu_cin, cin);
        chk("ready_busy", bus.instr_ready, 0);
        chk("res_valid_early", bus.res_valid, 0);
        @(negedge clk);
        chk("res_valid", bus.res_valid, 1);
        chk("res_data", bus.res_data, res);
        chk("res_flags", bus.res_flags, {co, a < b, a == b, a > b});
        chk("alu_x_idle", bus.alu_x, 0);
        ref_write(rd, res);
        ref_carry = co;
        @(negedge clk);
        chk("res_valid_pulse", bus.res_valid, 0);
        chk("res_hold", bus.res_data, res);
        rd_check("rf_rd", rd);
    endtask

    task automatic illegal_op(input logic [2:0] op, input logic [2:0] rd);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = {op, rd, 3'd1, 3'd2, 4'b0001};
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("illegal", bus.illegal, 1);
        chk("ready_illegal", bus.instr_ready, 1);
        chk("alu_op_illegal", bus.alu_op, 0);
        @(negedge clk);
        chk("illegal_pulse", bus.illegal, 0);
        chk("res_valid_illegal", bus.res_valid, 0);
        rd_check("rf_illegal", rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        ref_reset();
        #2 rst_n = 1'b0;
        #1 chk("ready_in_reset", bus.instr_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", bus.instr_ready, 1);
        chk("res_valid_reset", bus.res_valid, 0);
        chk("res_data_reset", bus.res_data, 0);
        chk("res_flags_reset", bus.res_flags, 0);
        chk("illegal_reset", bus.illegal, 0);
        chk("alu_x_reset", bus.alu_x, 0);
        for (int i = 0; i < 8; i++) rd_check("rf_reset", 3'(i));

        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);

        preload(3'd1, 16'hFFFF);
        preload(3'd2, 16'h0001);
        issue(3'd0, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("carry_set", bus.res_flags[3], 1);
        issue(3'd0, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0);
        chk("adc_result", bus.res_data, 16'h0001);

        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        issue(3'd1, 3'd6, 3'd2, 3'd1, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("sub_result", bus.res_data, 16'hFFFE);

        illegal_op(3'd5, 3'd3);
        illegal_op(3'd7, 3'd6);

        issue(3'd2, 3'd1, 3'd1, 3'd1, 1'b0, 1'b1, 3'd1, 16'h0100);
        issue(3'd3, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);

`ifdef ALU_ISSUE_R0ZERO_EN
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        issue(3'd3, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("r0_or_result", bus.res_data, 16'h0007);
        rd_check("r0_zero", 3'd0);
        chk("r0_model", ref_rf[0], 16'h0000);
        preload(3'd0, 16'h1234);
        rd_check("r0_preload", 3'd0);
`endif

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0)
                illegal_op(3'($urandom_range(4, 7)), 3'($urandom_range(0, 7)));
            else if ($urandom_range(0, 3) == 0)
                preload(3'($urandom_range(0, 7)), 16'($urandom));
            else
                issue(3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), 16'($urandom));
        end
        for (int i = 0; i < 8; i++) rd_check("rf_final", 3'(i));

        preload(3'd1, 16'h1111);
        preload(3'd2, 16'h2222);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = {3'd0, 3'd7, 3'd1, 3'd2, 4'b0000};
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ready_mid_reset", bus.instr_ready, 0);
        chk("alu_x_mid_reset", bus.alu_x, 0);
        chk("res_valid_mid_reset", bus.res_valid, 0);
        ref_reset();
        @(negedge clk);
        chk("res_valid_in_reset", bus.res_valid, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("res_valid_after_reset", bus.res_valid, 0);
            chk("ready_after_abort", bus.instr_ready, 1);
        end
        rd_check("rf7_abandoned", 3'd7);
        rd_check("rf1_cleared", 3'd1);
        issue(3'd0, 3'd7, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
